// File: rtl/fpgamem_arb_pkg.sv
// Shared types, default sizes and burst-length helper for the on-chip RAM arbiter.
package fpgamem_arb_pkg;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 64;
    localparam int BE_W      = DATA_W / 8;
    localparam int MAX_BURST = 16;
    localparam int BC_W      = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } arb_state_t;

    // Index of a requesting master: 0 or 1.
    typedef logic port_idx_t;

    // A burstcount of 0 means a single beat; anything above the limit is clamped.
    function automatic int unsigned norm_burst(input int unsigned bc, input int unsigned max_burst);
        int unsigned beats;
        beats = bc;
        if (bc == 0) begin
            beats = 1;
        end else if (bc > max_burst) begin
            beats = max_burst;
        end
        return beats;
    endfunction

endpackage

// File: rtl/fpgamem_rr_arbiter.sv
// Two-way round-robin picker: grants one requester and reports who holds priority next.
module fpgamem_rr_arbiter
    import fpgamem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  prio,
    output logic [1:0] grant,
    output port_idx_t  next_prio
);

    // Pick the priority port on contention, otherwise the lone requester.
    // NOTE: every output gets a default at the top so no path can leave it unassigned and infer a latch.
    always_comb begin
        grant     = 2'b00;
        next_prio = prio;
        if (req == 2'b11) begin
            grant = (prio == 1'b0) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
        if (grant[0]) begin
            next_prio = 1'b1;
        end else if (grant[1]) begin
            next_prio = 1'b0;
        end
    end

endmodule

// File: rtl/fpgamem_ocram_arbiter.sv
// Two-master Avalon-MM burst arbiter in front of a single-port, 1-cycle-latency on-chip RAM.
module fpgamem_ocram_arbiter #(
    parameter int ADDR_W    = fpgamem_arb_pkg::ADDR_W,
    parameter int DATA_W    = fpgamem_arb_pkg::DATA_W,
    parameter int BE_W      = fpgamem_arb_pkg::BE_W,
    parameter int MAX_BURST = fpgamem_arb_pkg::MAX_BURST,
    parameter int BC_W      = fpgamem_arb_pkg::BC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BC_W-1:0]   s0_burstcount,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BC_W-1:0]   s1_burstcount,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    import fpgamem_arb_pkg::*;

    arb_state_t        state, state_nxt;
    port_idx_t         prio, prio_nxt;
    port_idx_t         owner, owner_nxt;
    logic [ADDR_W-1:0] addr_cnt, addr_cnt_nxt;
    logic [BC_W-1:0]   beats_left, beats_left_nxt;
    logic              init_done;
    logic              rd_valid_q, rd_valid_nxt;
    port_idx_t         rd_owner_q, rd_owner_nxt;

    logic              active;
    logic [1:0]        req, grant;
    port_idx_t         rr_next_prio;

    port_idx_t         sel;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [BC_W-1:0]   sel_bc, sel_beats;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_data;

    // Commands are only considered in IDLE, and not until one full cycle after reset.
    assign active = init_done & ~reset;
    assign req    = {s1_read | s1_write, s0_read | s0_write} & {2{active & (state == IDLE)}};

    fpgamem_rr_arbiter u_rr (
        .req       (req),
        .prio      (prio),
        .grant     (grant),
        .next_prio (rr_next_prio)
    );

    // In IDLE follow the fresh winner; inside a burst follow the burst owner.
    assign sel       = (state == IDLE) ? grant[1] : owner;
    assign sel_beats = BC_W'(norm_burst(32'(sel_bc), MAX_BURST));

    assign mem_clken        = 1'b1;
    assign s0_readdata      = mem_readdata;
    assign s1_readdata      = mem_readdata;
    assign s0_readdatavalid = rd_valid_q & (rd_owner_q == 1'b0) & ~reset;
    assign s1_readdatavalid = rd_valid_q & (rd_owner_q == 1'b1) & ~reset;

    // Route the selected master's command and write beat onto shared wires.
    always_comb begin
        if (sel == 1'b1) begin
            sel_write = s1_write;
            sel_addr  = s1_address;
            sel_bc    = s1_burstcount;
            sel_be    = s1_byteenable;
            sel_data  = s1_writedata;
        end else begin
            sel_write = s0_write;
            sel_addr  = s0_address;
            sel_bc    = s0_burstcount;
            sel_be    = s0_byteenable;
            sel_data  = s0_writedata;
        end
    end

    // Next-state logic plus RAM-side and waitrequest outputs.
    always_comb begin
        state_nxt      = state;
        prio_nxt       = prio;
        owner_nxt      = owner;
        addr_cnt_nxt   = addr_cnt;
        beats_left_nxt = beats_left;
        rd_valid_nxt   = 1'b0;
        rd_owner_nxt   = rd_owner_q;
        s0_waitrequest = 1'b1;
        s1_waitrequest = 1'b1;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = addr_cnt;
        mem_byteenable = '1;
        mem_writedata  = sel_data;

        unique case (state)
            IDLE: begin
                if (grant != 2'b00) begin
                    s0_waitrequest = ~grant[0];
                    s1_waitrequest = ~grant[1];
                    mem_chipselect = 1'b1;
                    mem_write      = sel_write;
                    mem_address    = sel_addr;
                    if (sel_write) begin
                        mem_byteenable = sel_be;
                    end
                    rd_valid_nxt   = ~sel_write;
                    rd_owner_nxt   = sel;
                    owner_nxt      = sel;
                    addr_cnt_nxt   = sel_addr + ADDR_W'(1);
                    beats_left_nxt = sel_beats - BC_W'(1);
                    if (sel_beats == BC_W'(1)) begin
                        prio_nxt = rr_next_prio;
                    end else if (sel_write) begin
                        state_nxt = WR_BURST;
                    end else begin
                        state_nxt = RD_BURST;
                    end
                end
            end
            RD_BURST: begin
                mem_chipselect = 1'b1;
                rd_valid_nxt   = 1'b1;
                rd_owner_nxt   = owner;
                addr_cnt_nxt   = addr_cnt + ADDR_W'(1);
                beats_left_nxt = beats_left - BC_W'(1);
                if (beats_left == BC_W'(1)) begin
                    state_nxt = IDLE;
                    prio_nxt  = ~owner;
                end
            end
            WR_BURST: begin
                s0_waitrequest = (owner != 1'b0);
                s1_waitrequest = (owner != 1'b1);
                if (sel_write) begin
                    mem_chipselect = 1'b1;
                    mem_write      = 1'b1;
                    mem_byteenable = sel_be;
                    addr_cnt_nxt   = addr_cnt + ADDR_W'(1);
                    beats_left_nxt = beats_left - BC_W'(1);
                    if (beats_left == BC_W'(1)) begin
                        state_nxt = IDLE;
                        prio_nxt  = ~owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // While reset is high nothing is accepted or issued, whatever state is held.
        if (reset) begin
            s0_waitrequest = 1'b1;
            s1_waitrequest = 1'b1;
            mem_chipselect = 1'b0;
            mem_write      = 1'b0;
        end
    end

    // State, burst counters and the one-stage read-return pipeline.
    // NOTE: non-blocking assignments so every register here sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            addr_cnt   <= '0;
            beats_left <= '0;
            init_done  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            owner      <= owner_nxt;
            addr_cnt   <= addr_cnt_nxt;
            beats_left <= beats_left_nxt;
            init_done  <= 1'b1;
            rd_valid_q <= rd_valid_nxt;
            rd_owner_q <= rd_owner_nxt;
        end
    end

endmodule
